// File: rtl/bus_pkg.sv
// Shared definitions for the system-bus serial read-data path.
// Holds the frame width, the default completed-byte buffer depth and the
// 4-bit state encodings that the master and slave ports agree on.
package bus_pkg;

  localparam int BUS_DATA_WIDTH = 8;
  localparam int BUS_FIFO_DEPTH = 4;

  typedef enum logic [3:0] {
    IDLE = 4'd13,
    RECV = 4'd1
  } state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO for completed bytes.
// Ports:
//   clk, reset       rising-edge clock, synchronous active-low reset
//   push, din        write request and data; ignored when full unless a pop
//                    happens in the same cycle
//   pop              read request; ignored when empty
//   dout             head entry, zero when empty
//   full, empty      occupancy flags
//   count            number of stored entries (AW+1 bits)
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = empty ? '0 : mem[rd_ptr];

  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot wr_ptr points at, so the write is safe.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

endmodule

// File: rtl/master_in_port.sv
// Master-side receiver for the serial read-data path.
// Reassembles LSB-first frames from a slave output port, checks framing,
// buffers completed bytes and hands them out over valid/ready.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-low reset
//   read_en               master has a read open; gates master_ready
//   slave_valid, rx_bit   one data bit per cycle while valid
//   slave_tx_done         marks the last bit of a frame
//   master_ready          registered; room for one more whole frame
//   dout, dout_valid      FIFO head and non-empty flag
//   dout_ready            consumer pops the head
//   rx_busy               a frame is partially received
//   frame_err             one-cycle pulse on a framing error
//   overflow              sticky; a completed byte was dropped
//
// state | meaning
// IDLE  | between frames; a valid bit here is bit 0 of a new frame
// RECV  | bits 1..DATA_WIDTH-1 of the current frame expected
module master_in_port
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH = BUS_DATA_WIDTH,
  parameter int FIFO_DEPTH = BUS_FIFO_DEPTH,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_en,
  input  logic                  slave_valid,
  input  logic                  rx_bit,
  input  logic                  slave_tx_done,
  output logic                  master_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  rx_busy,
  output logic                  frame_err,
  output logic                  overflow
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-2:0] sh;     // the last bit goes straight to the FIFO

  logic                  push;
  logic                  pop;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  drop;
  logic                  full;
  logic                  empty;
  logic [AW:0]           count;
  logic [AW:0]           count_next;
  logic [AW:0]           free_next;
  logic                  inflight_next;
  logic [DATA_WIDTH-1:0] din;

  byte_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign dout_valid = !empty;
  assign pop        = dout_valid && dout_ready;
  assign din        = {rx_bit, sh};
  assign push       = (state == RECV) && slave_valid && (cnt == LAST) && slave_tx_done;

  assign push_ok    = push && (!full || pop);
  assign pop_ok     = pop && !empty;
  assign drop       = push && full && !pop;
  assign count_next = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
  assign free_next  = (AW+1)'(FIFO_DEPTH) - count_next;

  // A frame still in progress after this edge needs one slot reserved.
  assign inflight_next = slave_valid && !slave_tx_done &&
                         ((state == IDLE) || ((state == RECV) && (cnt < LAST)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      sh           <= '0;
      rx_busy      <= 1'b0;
      frame_err    <= 1'b0;
      overflow     <= 1'b0;
      master_ready <= 1'b0;
    end else begin
      frame_err    <= 1'b0;
      master_ready <= read_en && (free_next > {{AW{1'b0}}, inflight_next});
      if (drop) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (slave_valid) begin
            if (slave_tx_done) begin
              frame_err <= 1'b1;
            end else begin
              sh[0]   <= rx_bit;
              cnt     <= CNT_W'(1);
              rx_busy <= 1'b1;
              state   <= RECV;
            end
          end
        end

        RECV: begin
          if (!slave_valid) begin
            frame_err <= 1'b1;
            cnt       <= '0;
            rx_busy   <= 1'b0;
            state     <= IDLE;
          end else if (cnt < LAST) begin
            if (slave_tx_done) begin
              frame_err <= 1'b1;
              cnt       <= '0;
              rx_busy   <= 1'b0;
              state     <= IDLE;
            end else begin
              sh[cnt[IDX_W-1:0]] <= rx_bit;
              cnt                <= cnt + 1'b1;
            end
          end else begin
            // Last bit: the push itself happens combinationally above.
            if (!slave_tx_done) frame_err <= 1'b1;
            cnt     <= '0;
            rx_busy <= 1'b0;
            state   <= IDLE;
          end
        end

        default: begin
          cnt     <= '0;
          rx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_master_in_port.sv
module tb_master_in_port;

  logic       clk = 1'b0;
  logic       reset;
  logic       read_en;
  logic       slave_valid;
  logic       rx_bit;
  logic       slave_tx_done;
  logic       master_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       rx_busy;
  logic       frame_err;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  master_in_port dut (
    .clk           (clk),
    .reset         (reset),
    .read_en       (read_en),
    .slave_valid   (slave_valid),
    .rx_bit        (rx_bit),
    .slave_tx_done (slave_tx_done),
    .master_ready  (master_ready),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .rx_busy       (rx_busy),
    .frame_err     (frame_err),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected summary before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    slave_valid   = 1'b0;
    rx_bit        = 1'b0;
    slave_tx_done = 1'b0;
  endtask

  // Drive bits lo..hi of b; done flag on bit hi if requested.
  // Bits before hi must leave the receiver busy and error-free.
  task automatic send_range(input logic [7:0] b, input int lo, input int hi, input bit done);
    for (int i = lo; i <= hi; i++) begin
      slave_valid   = 1'b1;
      rx_bit        = b[i];
      slave_tx_done = done && (i == hi);
      tick();
      if (i < hi) begin
        chk("busy_mid", rx_busy, 1);
        chk("err_mid", frame_err, 0);
      end
    end
  endtask

  task automatic drain();
    dout_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (!dout_valid) break;
      if (exp_q.size() == 0) chk("sb_extra", dout_valid, 0);
      else chk("sb_data", dout, exp_q.pop_front());
      tick();
    end
    dout_ready = 1'b0;
    chk("sb_left", exp_q.size(), 0);
    chk("drain_empty", dout_valid, 0);
  endtask

  initial begin
    reset = 1'b0; read_en = 1'b1; dout_ready = 1'b0;
    idle();
    tick(); tick();
    chk("rst_mready", master_ready, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b1;
    tick();
    chk("mready_idle", master_ready, 1);

    read_en = 1'b0; tick();
    chk("mready_noread", master_ready, 0);
    read_en = 1'b1; tick();
    chk("mready_read", master_ready, 1);

    // Single frame 0xA5
    send_range(8'hA5, 0, 7, 1); exp_q.push_back(8'hA5);
    chk("a5_valid", dout_valid, 1);
    chk("a5_dout", dout, 8'hA5);
    chk("a5_err", frame_err, 0);
    chk("a5_busy", rx_busy, 0);
    idle(); tick();
    drain();

    // Back-to-back 0x3C, 0xC3 with valid held high
    send_range(8'h3C, 0, 7, 1); exp_q.push_back(8'h3C);
    chk("b2b_gap_busy", rx_busy, 0);
    send_range(8'hC3, 0, 0, 0);
    chk("b2b_restart_busy", rx_busy, 1);
    send_range(8'hC3, 1, 7, 1); exp_q.push_back(8'hC3);
    idle(); tick();
    chk("b2b_head", dout, 8'h3C);
    drain();

    // Truncated frame
    send_range(8'hFF, 0, 4, 0);
    idle(); tick();
    chk("trunc_err", frame_err, 1);
    chk("trunc_busy", rx_busy, 0);
    chk("trunc_valid", dout_valid, 0);
    tick();
    chk("trunc_err_pulse", frame_err, 0);
    send_range(8'h01, 0, 7, 1); exp_q.push_back(8'h01);
    idle(); tick();
    drain();

    // Done in IDLE, early done, missing done
    slave_valid = 1'b1; rx_bit = 1'b1; slave_tx_done = 1'b1;
    tick();
    chk("idle_done_err", frame_err, 1);
    chk("idle_done_busy", rx_busy, 0);
    idle(); tick();
    chk("idle_done_pulse", frame_err, 0);
    send_range(8'h55, 0, 3, 1);
    chk("early_done_err", frame_err, 1);
    chk("early_done_busy", rx_busy, 0);
    idle(); tick();
    send_range(8'hAA, 0, 7, 0);
    chk("nodone_err", frame_err, 1);
    chk("nodone_valid", dout_valid, 0);
    idle(); tick();

    // Fill FIFO, then simultaneous push+pop when full
    send_range(8'h11, 0, 7, 1); exp_q.push_back(8'h11); idle(); tick();
    send_range(8'h22, 0, 7, 1); exp_q.push_back(8'h22); idle(); tick();
    send_range(8'h4B, 0, 7, 1); exp_q.push_back(8'h4B); idle(); tick();
    chk("fill3_mready", master_ready, 1);
    send_range(8'h96, 0, 0, 0);
    chk("fill4_start_mready", master_ready, 0);
    send_range(8'h96, 1, 7, 1); exp_q.push_back(8'h96);
    idle(); tick();
    chk("full_mready", master_ready, 0);
    chk("full_head", dout, 8'h11);
    send_range(8'hF0, 0, 6, 0);
    slave_valid = 1'b1; rx_bit = 1'b1; slave_tx_done = 1'b1; dout_ready = 1'b1;
    chk("sb_data", dout, exp_q.pop_front());
    tick();
    dout_ready = 1'b0; exp_q.push_back(8'hF0);
    idle(); tick();
    chk("pushpop_ovf", overflow, 0);
    chk("pushpop_mready", master_ready, 0);
    chk("pushpop_head", dout, exp_q[0]);

    // Overflow: fifth frame dropped
    send_range(8'h0F, 0, 7, 1);
    chk("ovf_set", overflow, 1);
    chk("ovf_head", dout, exp_q[0]);
    idle(); tick();
    drain();
    chk("ovf_sticky", overflow, 1);

    // Reset during bit 3 of a frame
    send_range(8'h77, 0, 7, 1); idle(); tick();
    send_range(8'h5A, 0, 2, 0);
    slave_valid = 1'b1; rx_bit = 1'b1; reset = 1'b0;
    tick();
    exp_q.delete();
    chk("mrst_mready", master_ready, 0);
    chk("mrst_valid", dout_valid, 0);
    chk("mrst_dout", dout, 0);
    chk("mrst_busy", rx_busy, 0);
    chk("mrst_err", frame_err, 0);
    chk("mrst_ovf", overflow, 0);
    reset = 1'b1; idle();
    tick();
    chk("mrst_release_mready", master_ready, 1);
    chk("mrst_release_err", frame_err, 0);
    send_range(8'hE7, 0, 7, 1); exp_q.push_back(8'hE7);
    idle(); tick();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/master_in_port.md
Name: master_in_port

Overview:
- Master-side receiver for the serial read-data path of the system bus.
- Reassembles the LSB-first bit stream driven by a slave's output port (slave_valid / tx_data / slave_tx_done) into bytes.
- Checks framing, buffers completed bytes in a small FIFO, and presents them to master logic over a valid/ready interface.
- Drives master_ready back to the slave so that a slave only starts a byte when the FIFO has room for it.

Parameters:
- DATA_WIDTH, 8: bits per frame; fixed 8 on this bus, kept as a parameter for counter sizing.
- FIFO_DEPTH, 4: completed-byte buffer entries; power of 2, minimum 2.
- CNT_W, 4: bit-counter width; must satisfy 2^CNT_W > DATA_WIDTH.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- read_en  input  1  master has a read transaction open; gates master_ready.
- slave_valid  input  1  slave is presenting a data bit this cycle.
- rx_bit  input  1  serial data from the slave's tx_data.
- slave_tx_done  input  1  slave marks the last bit of the frame.
- master_ready  output  1  registered; the receiver can accept one more whole frame.
- dout  output  DATA_WIDTH  FIFO head byte.
- dout_valid  output  1  FIFO non-empty.
- dout_ready  input  1  consumer pops the head when dout_valid && dout_ready.
- rx_busy  output  1  a frame is partially received.
- frame_err  output  1  one-cycle pulse on a framing error.
- overflow  output  1  sticky; a completed byte was dropped because the FIFO was full.

Behaviour:
- Reset (reset==0 at a clk edge):
  - master_ready=0, dout_valid=0, dout=0, rx_busy=0, frame_err=0, overflow=0.
  - FIFO emptied, bit counter=0, shift register=0, state=IDLE.
  - A reset mid-frame discards the partial byte; no frame_err is raised.
- Bit timing: one bit per cycle while slave_valid=1, LSB first. Bit i of the frame lands in byte bit i. The 8th bit coincides with slave_tx_done=1.
- FSM, IDLE:
  - slave_valid=1: store rx_bit in sh[0], cnt<=1, rx_busy<=1, go to RECV.
  - slave_valid=1 together with slave_tx_done=1: framing error. Pulse frame_err and stay in IDLE.
- FSM, RECV:
  - slave_valid=0: frame truncated. Pulse frame_err, discard, go to IDLE with rx_busy<=0.
  - slave_valid=1 and cnt<DATA_WIDTH-1:
    - If slave_tx_done=1: early done. Pulse frame_err, discard, go to IDLE.
    - Otherwise: sh[cnt]<=rx_bit, cnt<=cnt+1.
  - slave_valid=1 and cnt==DATA_WIDTH-1 (last bit):
    - If slave_tx_done=1: push {rx_bit, sh[6:0]} to the FIFO.
    - If slave_tx_done=0: pulse frame_err, discard.
    - Either way: cnt<=0, rx_busy<=0, go to IDLE.
- Back-to-back frames: slave_valid may stay high. The IDLE cycle that follows a completed frame captures the next bit 0, with no bubble required.
- FIFO:
  - Push and pop in the same cycle are both honoured, including when full.
  - Push when full with no pop: byte dropped, overflow<=1 (cleared only by reset).
  - dout / dout_valid reflect the head with zero added latency. The byte appears the cycle after its last bit is sampled.
- master_ready (registered): 1 iff read_en=1 and free_next > inflight_next, where:
  - free_next = FIFO_DEPTH - count after this cycle's push/pop;
  - inflight_next = 1 if state_next==RECV, else 0.
  - master_ready may deassert mid-frame; the slave only samples it between frames.
- Counters: cnt wraps only through explicit clear. FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared package bus_pkg:
  - DATA_WIDTH;
  - state encodings IDLE=4'd13 and RECV=4'd1 (4-bit, consistent with the slave port);
  - FIFO_DEPTH default.
- Sub-module byte_fifo:
  - synchronous FIFO with push/pop/din/dout/full/empty/count;
  - same clk and active-low synchronous reset.
- master_in_port holds the FSM, shift register, framing checks and master_ready logic.

Test Plan:
- Single frame 0xA5 (bits 1,0,1,0,0,1,0,1; slave_tx_done on bit 8), read_en=1, dout_ready=0 -> dout=0xA5 and dout_valid=1 the cycle after bit 8; frame_err stays 0.
- Back-to-back 0x3C then 0xC3 with slave_valid held high for 16 cycles -> FIFO holds 0x3C then 0xC3; popping yields them in order; rx_busy low for exactly the one IDLE cycle between frames.
- slave_valid drops after 5 bits -> frame_err pulses one cycle, no push, dout_valid stays 0; the next clean frame 0x01 is received correctly.
- Fill the FIFO with 4 frames, dout_ready=0 -> master_ready=0 from the cycle the 4th frame starts; force a 5th frame -> overflow=1, FIFO contents unchanged.
- FIFO full, then push and pop in the same cycle -> count stays 4, the new byte is at the tail, overflow stays 0.
- Assert reset=0 during bit 3 of a frame -> all outputs 0 the next cycle, FIFO empty; master_ready returns to 1 one cycle after release with read_en=1.
